// File: rtl/xip_prefetch_engine.sv
// Single-line XIP prefetch buffer. It serves AXI4-Lite reads from the buffered line
// when possible; otherwise it fetches a whole line through the QSPI FSM and RX FIFO.
module xip_prefetch_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  xip_en_i,
    input  logic                  cmd_busy_i,
    input  logic                  flush_i,
    input  logic [7:0]            xip_read_op_i,
    input  logic [1:0]            xip_addr_bytes_i,
    input  logic [1:0]            xip_data_lanes_i,
    input  logic [3:0]            xip_dummy_cycles_i,
    input  logic [2:0]            clk_div_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [31:0]           rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [31:0]           fifo_rx_data_i,
    input  logic                  fifo_rx_empty_i,
    output logic                  fifo_rx_re_o,
    output logic                  start_o,
    input  logic                  done_i,
    output logic [7:0]            opcode_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           len_o,
    output logic [1:0]            addr_bytes_o,
    output logic [1:0]            data_lanes_o,
    output logic [3:0]            dummy_cycles_o,
    output logic [31:0]           clk_div_o,
    output logic                  busy_o,
    output logic                  hit_o,
    output logic                  miss_o
);
    localparam int LB = $clog2(LINE_WORDS * 4);
    localparam int IW = LB - 2;
    localparam int CW = $clog2(LINE_WORDS) + 1;
    localparam int TW = ADDR_WIDTH - LB;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RESP = 2'd2} state_t;

    state_t          state_reg;
    logic [31:0]     line_mem [LINE_WORDS];
    logic [TW-1:0]   tag_reg;
    logic [IW-1:0]   idx_reg;
    logic            valid_reg;
    logic            flush_pend_reg;
    logic            done_flag_reg;
    logic [CW-1:0]   fill_cnt_reg;
    logic [4:0]      starve_cnt_reg;

    logic [TW-1:0]   ar_tag;
    logic [IW-1:0]   ar_idx;
    logic            ar_fire;
    logic            fill_full;
    logic            starving;
    logic            unused_addr_lsb;

    assign ar_tag          = araddr_i[ADDR_WIDTH-1:LB];
    assign ar_idx          = araddr_i[LB-1:2];
    assign unused_addr_lsb = ^araddr_i[1:0];
    assign arready_o       = (state_reg == IDLE) && xip_en_i && !cmd_busy_i;
    assign ar_fire         = arvalid_i && arready_o;
    assign fill_full       = (fill_cnt_reg == CW'(LINE_WORDS));
    assign fifo_rx_re_o    = (state_reg == FILL) && !fifo_rx_empty_i && !fill_full;
    // Starvation only counts once the flash side has declared itself finished.
    assign starving        = (done_flag_reg || done_i) && !fill_full && fifo_rx_empty_i;
    assign busy_o          = (state_reg != IDLE);

    // Line storage: written only by FIFO pops, no reset needed.
    always_ff @(posedge clk) begin
        if (fifo_rx_re_o)
            line_mem[fill_cnt_reg[IW-1:0]] <= fifo_rx_data_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            tag_reg        <= '0;
            idx_reg        <= '0;
            valid_reg      <= 1'b0;
            flush_pend_reg <= 1'b0;
            done_flag_reg  <= 1'b0;
            fill_cnt_reg   <= '0;
            starve_cnt_reg <= '0;
            rdata_o        <= '0;
            rresp_o        <= 2'b00;
            rvalid_o       <= 1'b0;
            start_o        <= 1'b0;
            hit_o          <= 1'b0;
            miss_o         <= 1'b0;
            opcode_o       <= '0;
            addr_o         <= '0;
            len_o          <= '0;
            addr_bytes_o   <= '0;
            data_lanes_o   <= '0;
            dummy_cycles_o <= '0;
            clk_div_o      <= '0;
        end else begin
            start_o <= 1'b0;
            hit_o   <= 1'b0;
            miss_o  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (flush_i)
                        valid_reg <= 1'b0;
                    if (ar_fire) begin
                        if (valid_reg && (tag_reg == ar_tag)) begin
                            rdata_o   <= line_mem[ar_idx];
                            rresp_o   <= 2'b00;
                            rvalid_o  <= 1'b1;
                            hit_o     <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            valid_reg      <= 1'b0;
                            tag_reg        <= ar_tag;
                            idx_reg        <= ar_idx;
                            fill_cnt_reg   <= '0;
                            done_flag_reg  <= 1'b0;
                            flush_pend_reg <= 1'b0;
                            starve_cnt_reg <= '0;
                            opcode_o       <= xip_read_op_i;
                            addr_o         <= {ar_tag, {LB{1'b0}}};
                            len_o          <= 32'(LINE_WORDS * 4);
                            addr_bytes_o   <= xip_addr_bytes_i;
                            data_lanes_o   <= xip_data_lanes_i;
                            dummy_cycles_o <= xip_dummy_cycles_i;
                            clk_div_o      <= {29'd0, clk_div_i};
                            start_o        <= 1'b1;
                            miss_o         <= 1'b1;
                            state_reg      <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (fifo_rx_re_o)
                        fill_cnt_reg <= fill_cnt_reg + 1'b1;
                    if (done_i)
                        done_flag_reg <= 1'b1;
                    if (flush_i)
                        flush_pend_reg <= 1'b1;
                    if (fill_full && done_flag_reg) begin
                        valid_reg <= !(flush_pend_reg || flush_i);
                        rdata_o   <= line_mem[idx_reg];
                        rresp_o   <= 2'b00;
                        rvalid_o  <= 1'b1;
                        state_reg <= RESP;
                    end else if (starving) begin
                        if (starve_cnt_reg == 5'd15) begin
                            rdata_o   <= '0;
                            rresp_o   <= 2'b10;
                            rvalid_o  <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            starve_cnt_reg <= starve_cnt_reg + 1'b1;
                        end
                    end else begin
                        starve_cnt_reg <= '0;
                    end
                end
                RESP: begin
                    if (flush_i)
                        valid_reg <= 1'b0;
                    if (rready_i) begin
                        rvalid_o  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    rvalid_o  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xip_prefetch_engine.sv
// Directed bench for xip_prefetch_engine (LINE_WORDS=4): hits, misses, flush,
// starvation error, AR gating and asynchronous reset.
module tb_xip_prefetch_engine;
    logic        clk = 1'b0;
    logic        resetn;
    logic        xip_en, cmd_busy, flush;
    logic [7:0]  read_op;
    logic [1:0]  addr_bytes, data_lanes;
    logic [3:0]  dummy;
    logic [2:0]  clk_div;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] fifo_data;
    logic        fifo_empty, fifo_re;
    logic        start, done;
    logic [7:0]  opcode;
    logic [31:0] addr_o, len_o, clk_div_o;
    logic [1:0]  addr_bytes_o, data_lanes_o;
    logic [3:0]  dummy_o;
    logic        busy, hit, miss;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xip_prefetch_engine #(.ADDR_WIDTH(32), .LINE_WORDS(4)) dut (
        .clk(clk), .resetn(resetn), .xip_en_i(xip_en), .cmd_busy_i(cmd_busy), .flush_i(flush),
        .xip_read_op_i(read_op), .xip_addr_bytes_i(addr_bytes), .xip_data_lanes_i(data_lanes),
        .xip_dummy_cycles_i(dummy), .clk_div_i(clk_div),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
        .fifo_rx_data_i(fifo_data), .fifo_rx_empty_i(fifo_empty), .fifo_rx_re_o(fifo_re),
        .start_o(start), .done_i(done),
        .opcode_o(opcode), .addr_o(addr_o), .len_o(len_o), .addr_bytes_o(addr_bytes_o),
        .data_lanes_o(data_lanes_o), .dummy_cycles_o(dummy_o), .clk_div_o(clk_div_o),
        .busy_o(busy), .hit_o(hit), .miss_o(miss)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one AR beat; returns at the negedge after acceptance.
    task automatic ar(input logic [31:0] a);
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        #1 chk("arready", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        $display("AR 0x%08h hit=%0b miss=%0b start=%0b", a, hit, miss, start);
    endtask

    // Supply n words base+i, done_i with the last one, optional flush on word 1.
    task automatic fill(input logic [31:0] base, input int n, input bit flush_mid);
        for (int i = 0; i < n; i++) begin
            fifo_data  = base + i;
            fifo_empty = 1'b0;
            done       = (i == n - 1);
            flush      = flush_mid && (i == 1);
            #1 chk("fifo_re", fifo_re, 1'b1);
            @(negedge clk);
        end
        fifo_empty = 1'b1;
        done       = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic wait_rvalid();
        for (int n = 0; n < 40 && rvalid !== 1'b1; n++)
            @(negedge clk);
        chk("rvalid_wait", rvalid, 1'b1);
    endtask

    task automatic respond(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        chk({tag, "_rdata"}, rdata, exp_data);
        chk({tag, "_rresp"}, rresp, exp_resp);
        $display("R %s rdata=0x%08h rresp=%0d", tag, rdata, rresp);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk({tag, "_rvalid_low"}, rvalid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; xip_en = 1'b1; cmd_busy = 1'b0; flush = 1'b0;
        read_op = 8'hEB; addr_bytes = 2'd2; data_lanes = 2'd3; dummy = 4'd6; clk_div = 3'd5;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        fifo_data = '0; fifo_empty = 1'b1; done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_len", len_o, 32'h0);
        chk("rst_arready", arready, 1'b1);
        resetn = 1'b1;

        // First miss: config latched, minimum latency LINE_WORDS+1
        ar(32'h1008);
        chk("m1_miss", miss, 1'b1);
        chk("m1_start", start, 1'b1);
        chk("m1_hit", hit, 1'b0);
        chk("m1_addr", addr_o, 32'h1000);
        chk("m1_len", len_o, 32'd16);
        chk("m1_opcode", opcode, 8'hEB);
        chk("m1_clkdiv", clk_div_o, 32'd5);
        chk("m1_dummy", dummy_o, 4'd6);
        chk("m1_lanes", data_lanes_o, 2'd3);
        chk("m1_abytes", addr_bytes_o, 2'd2);
        chk("m1_busy", busy, 1'b1);
        fill(32'hA000_0000, 4, 1'b0);
        chk("m1_rvalid_early", rvalid, 1'b0);
        @(negedge clk);
        chk("m1_rvalid", rvalid, 1'b1);
        respond("m1", 32'hA000_0002, 2'b00);

        // Hits on the buffered line
        ar(32'h1004);
        chk("h1_hit", hit, 1'b1);
        chk("h1_start", start, 1'b0);
        chk("h1_miss", miss, 1'b0);
        chk("h1_rvalid", rvalid, 1'b1);
        respond("h1", 32'hA000_0001, 2'b00);
        ar(32'h100C);
        chk("h2_hit", hit, 1'b1);
        chk("h2_start", start, 1'b0);
        respond("h2", 32'hA000_0003, 2'b00);

        // Line replacement
        ar(32'h2000);
        chk("m2_miss", miss, 1'b1);
        chk("m2_addr", addr_o, 32'h2000);
        fill(32'hB000_0000, 4, 1'b0);
        wait_rvalid();
        respond("m2", 32'hB000_0000, 2'b00);
        ar(32'h1000);
        chk("m3_miss", miss, 1'b1);
        fill(32'hA000_0000, 4, 1'b0);
        wait_rvalid();
        respond("m3", 32'hA000_0000, 2'b00);

        // Flush during fill: word returned, line left invalid
        ar(32'h3000);
        chk("f1_miss", miss, 1'b1);
        fill(32'hC000_0000, 4, 1'b1);
        wait_rvalid();
        respond("f1", 32'hC000_0000, 2'b00);
        ar(32'h3000);
        chk("f2_miss", miss, 1'b1);
        fill(32'hC000_0000, 4, 1'b0);
        wait_rvalid();
        respond("f2", 32'hC000_0000, 2'b00);
        ar(32'h3004);
        chk("f3_hit", hit, 1'b1);
        respond("f3", 32'hC000_0001, 2'b00);

        // Short fill: done after 2 words, FIFO starves -> SLVERR held stable
        ar(32'h4008);
        chk("e1_miss", miss, 1'b1);
        fill(32'hD000_0000, 2, 1'b0);
        wait_rvalid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("e1_hold_rvalid", rvalid, 1'b1);
            chk("e1_hold_rdata", rdata, 32'h0);
            chk("e1_hold_rresp", rresp, 2'b10);
        end
        respond("e1", 32'h0, 2'b10);

        // Line never validated: same address misses; reset it mid-fill
        ar(32'h4008);
        chk("e2_miss", miss, 1'b1);
        fifo_data  = 32'hE000_0000;
        fifo_empty = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("r_busy", busy, 1'b0);
        chk("r_fifo_re", fifo_re, 1'b0);
        chk("r_start", start, 1'b0);
        chk("r_rvalid", rvalid, 1'b0);
        chk("r_addr", addr_o, 32'h0);
        chk("r_len", len_o, 32'h0);
        chk("r_opcode", opcode, 8'h0);
        $display("RESET mid-fill busy=%0b fifo_re=%0b", busy, fifo_re);
        @(negedge clk);
        fifo_empty = 1'b1;
        resetn     = 1'b1;

        // AR gating
        cmd_busy = 1'b1;
        araddr   = 32'h3004;
        arvalid  = 1'b1;
        #1 chk("g_busy_arready", arready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("g_busy_idle", busy, 1'b0);
        cmd_busy = 1'b0;
        xip_en   = 1'b0;
        #1 chk("g_en_arready", arready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("g_en_idle", busy, 1'b0);
        arvalid = 1'b0;
        xip_en  = 1'b1;
        $display("GATE checks done");

        // First AR after reset misses even on a previously valid line
        ar(32'h3004);
        chk("p_miss", miss, 1'b1);
        chk("p_hit", hit, 1'b0);
        fill(32'hC000_0000, 4, 1'b0);
        wait_rvalid();
        respond("p", 32'hC000_0001, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
